// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with overflow/underflow pulses.
// Optional misprediction checkpointing is enabled by defining RAS_CHECKPOINT_EN.

package config_pkg;
    parameter int VLEN = 64;
endpackage

module ras_stack #(
    parameter int VLEN  = config_pkg::VLEN,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  logic [1:0]               ras_ctl_i,
    input  logic [VLEN-1:0]          push_addr_i,
`ifdef RAS_CHECKPOINT_EN
    input  logic                     ckpt_save_i,
    input  logic                     ckpt_restore_i,
`endif
    output logic                     pred_valid_o,
    output logic [VLEN-1:0]          pred_addr_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        CtlPush    = 2'b00,
        CtlPop     = 2'b01,
        CtlPushPop = 2'b10,
        CtlNop     = 2'b11
    } ras_ctl_e;

    logic [VLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]   tos_q, tos_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;
    logic            wr_en;
    logic [PW-1:0]   wr_addr;
    logic [VLEN-1:0] wr_data;
    logic            is_empty, is_full;

`ifdef RAS_CHECKPOINT_EN
    logic [PW-1:0]   ckpt_tos_q;
    logic [CW-1:0]   ckpt_count_q;
    logic [VLEN-1:0] ckpt_top_q;
    logic            restore;
    assign restore = ckpt_restore_i;
`else
    logic            restore;
    assign restore = 1'b0;
`endif

    assign is_empty     = (count_q == '0);
    assign is_full      = (count_q == CW'(DEPTH));
    assign pred_valid_o = !is_empty;
    assign pred_addr_o  = is_empty ? '0 : mem_q[tos_q];
    assign count_o      = count_q;
    assign overflow_o   = overflow_q;
    assign underflow_o  = underflow_q;

    always_comb begin
        tos_d       = tos_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = tos_q;
        wr_data     = push_addr_i;
        if (flush_i) begin
            tos_d   = '0;
            count_d = '0;
        end else if (restore) begin
`ifdef RAS_CHECKPOINT_EN
            tos_d   = ckpt_tos_q;
            count_d = ckpt_count_q;
            wr_en   = 1'b1;
            wr_addr = ckpt_tos_q;
            wr_data = ckpt_top_q;
`endif
        end else if (valid_i) begin
            unique case (ras_ctl_e'(ras_ctl_i))
                CtlPop: begin
                    if (is_empty) begin
                        underflow_d = 1'b1;
                    end else begin
                        tos_d   = tos_q - 1'b1;
                        count_d = count_q - 1'b1;
                    end
                end
                CtlPush, CtlPushPop: begin
                    // Push+pop on a non-empty stack replaces the top in place.
                    if (ras_ctl_i == CtlPushPop && !is_empty) begin
                        wr_en = 1'b1;
                    end else begin
                        tos_d      = tos_q + 1'b1;
                        wr_en      = 1'b1;
                        wr_addr    = tos_q + 1'b1;
                        count_d    = is_full ? count_q : count_q + 1'b1;
                        overflow_d = is_full;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tos_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tos_q       <= tos_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage is deliberately unreset; the empty mask hides stale data.
    always_ff @(posedge clk_i) begin
        if (wr_en && rst_ni) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

`ifdef RAS_CHECKPOINT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ckpt_tos_q   <= '0;
            ckpt_count_q <= '0;
            ckpt_top_q   <= '0;
        end else if (ckpt_save_i && !ckpt_restore_i) begin
            ckpt_tos_q   <= tos_q;
            ckpt_count_q <= count_q;
            ckpt_top_q   <= mem_q[tos_q];
        end
    end
`endif

endmodule

// File: tb/tb_ras_stack.sv
// Directed self-checking bench for ras_stack (DEPTH=4, VLEN=64).
// Checkpoint steps run only when RAS_CHECKPOINT_EN is defined.

module tb_ras_stack;

    localparam int VLEN  = 64;
    localparam int DEPTH = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             flush_i;
    logic             valid_i;
    logic [1:0]       ras_ctl_i;
    logic [VLEN-1:0]  push_addr_i;
    logic             ckpt_save_i;
    logic             ckpt_restore_i;
    logic             pred_valid_o;
    logic [VLEN-1:0]  pred_addr_o;
    logic [2:0]       count_o;
    logic             overflow_o;
    logic             underflow_o;

    int compared   = 0;
    int mismatched = 0;

    ras_stack #(.VLEN(VLEN), .DEPTH(DEPTH)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .valid_i        (valid_i),
        .ras_ctl_i      (ras_ctl_i),
        .push_addr_i    (push_addr_i),
`ifdef RAS_CHECKPOINT_EN
        .ckpt_save_i    (ckpt_save_i),
        .ckpt_restore_i (ckpt_restore_i),
`endif
        .pred_valid_o   (pred_valid_o),
        .pred_addr_o    (pred_addr_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic applyStimulus(input logic fl, input logic vld, input logic [1:0] ctl,
                                 input logic [VLEN-1:0] addr);
        flush_i     = fl;
        valid_i     = vld;
        ras_ctl_i   = ctl;
        push_addr_i = addr;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        applyStimulus(1'b0, 1'b0, 2'b11, '0);
        ckpt_save_i    = 1'b0;
        ckpt_restore_i = 1'b0;
    endtask

    task automatic doOp(input logic [1:0] ctl, input logic [VLEN-1:0] addr);
        applyStimulus(1'b0, 1'b1, ctl, addr);
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic [VLEN-1:0] ea,
                               input logic [2:0] ec, input logic eo, input logic eu);
        compared++;
        assert (pred_valid_o === ev) else begin
            mismatched++;
            $error("[TB] FAIL %s pred_valid got %0b want %0b", tag, pred_valid_o, ev);
        end
        compared++;
        assert (pred_addr_o === ea) else begin
            mismatched++;
            $error("[TB] FAIL %s pred_addr got %h want %h", tag, pred_addr_o, ea);
        end
        compared++;
        assert (count_o === ec) else begin
            mismatched++;
            $error("[TB] FAIL %s count got %0d want %0d", tag, count_o, ec);
        end
        compared++;
        assert (overflow_o === eo) else begin
            mismatched++;
            $error("[TB] FAIL %s overflow got %0b want %0b", tag, overflow_o, eo);
        end
        compared++;
        assert (underflow_o === eu) else begin
            mismatched++;
            $error("[TB] FAIL %s underflow got %0b want %0b", tag, underflow_o, eu);
        end
    endtask

    initial begin
        rst_ni         = 1'b0;
        ckpt_save_i    = 1'b0;
        ckpt_restore_i = 1'b0;
        applyStimulus(1'b0, 1'b1, 2'b00, 64'hdead);
        tick();
        applyStimulus(1'b0, 1'b1, 2'b00, 64'hbeef);
        tick();
        checkOutput("reset", 1'b0, '0, 3'd0, 1'b0, 1'b0);
        rst_ni = 1'b1;

        // Basic push/push/pop
        doOp(2'b00, 64'h1000);
        doOp(2'b00, 64'h2000);
        checkOutput("push2", 1'b1, 64'h2000, 3'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b01, '0);
        #1;
        checkOutput("pop_same_cycle", 1'b1, 64'h2000, 3'd2, 1'b0, 1'b0);
        tick();
        checkOutput("pop_after", 1'b1, 64'h1000, 3'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b11, '0);
        tick();
        checkOutput("flush", 1'b0, '0, 3'd0, 1'b0, 1'b0);

        // Overflow: five pushes into a four-entry stack
        doOp(2'b00, 64'h10);
        doOp(2'b00, 64'h20);
        doOp(2'b00, 64'h30);
        doOp(2'b00, 64'h40);
        checkOutput("full_no_ovf", 1'b1, 64'h40, 3'd4, 1'b0, 1'b0);
        doOp(2'b00, 64'h50);
        checkOutput("overflow", 1'b1, 64'h50, 3'd4, 1'b1, 1'b0);
        doOp(2'b01, '0);
        checkOutput("ovf_pulse_end", 1'b1, 64'h40, 3'd3, 1'b0, 1'b0);
        doOp(2'b01, '0);
        checkOutput("pop_30", 1'b1, 64'h30, 3'd2, 1'b0, 1'b0);
        doOp(2'b01, '0);
        checkOutput("pop_20", 1'b1, 64'h20, 3'd1, 1'b0, 1'b0);
        doOp(2'b01, '0);
        checkOutput("drained", 1'b0, '0, 3'd0, 1'b0, 1'b0);

        // Underflow and flush suppression
        doOp(2'b01, '0);
        checkOutput("underflow", 1'b0, '0, 3'd0, 1'b0, 1'b1);
        tick();
        checkOutput("unf_pulse_end", 1'b0, '0, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b00, 64'h123);
        tick();
        checkOutput("flush_push", 1'b0, '0, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b01, '0);
        tick();
        checkOutput("flush_pop_empty", 1'b0, '0, 3'd0, 1'b0, 1'b0);

        // Push+pop on empty behaves as push; invalid / no-op change nothing
        doOp(2'b10, 64'h77);
        checkOutput("pushpop_empty", 1'b1, 64'h77, 3'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'b00, 64'h88);
        tick();
        checkOutput("valid_low", 1'b1, 64'h77, 3'd1, 1'b0, 1'b0);
        doOp(2'b11, 64'h99);
        checkOutput("ctl_nop", 1'b1, 64'h77, 3'd1, 1'b0, 1'b0);

        // Push+pop replaces top in place
        applyStimulus(1'b1, 1'b0, 2'b11, '0);
        tick();
        doOp(2'b00, 64'h1000);
        doOp(2'b00, 64'h2000);
        doOp(2'b10, 64'h3000);
        checkOutput("pushpop", 1'b1, 64'h3000, 3'd2, 1'b0, 1'b0);
        doOp(2'b01, '0);
        checkOutput("pushpop_then_pop", 1'b1, 64'h1000, 3'd1, 1'b0, 1'b0);

        // Reset mid-operation abandons it
        applyStimulus(1'b0, 1'b1, 2'b00, 64'h4444);
        #1;
        rst_ni = 1'b0;
        #2;
        checkOutput("reset_async", 1'b0, '0, 3'd0, 1'b0, 1'b0);
        tick();
        rst_ni = 1'b1;
        doOp(2'b01, '0);
        checkOutput("post_reset_empty", 1'b0, '0, 3'd0, 1'b0, 1'b1);

`ifdef RAS_CHECKPOINT_EN
        applyStimulus(1'b1, 1'b0, 2'b11, '0);
        tick();
        doOp(2'b00, 64'h1000);
        doOp(2'b00, 64'h2000);
        applyStimulus(1'b0, 1'b1, 2'b01, '0);
        ckpt_save_i = 1'b1;
        tick();
        checkOutput("ckpt_pop", 1'b1, 64'h1000, 3'd1, 1'b0, 1'b0);
        doOp(2'b00, 64'h9000);
        checkOutput("ckpt_push", 1'b1, 64'h9000, 3'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b00, 64'hAAAA);
        ckpt_restore_i = 1'b1;
        ckpt_save_i    = 1'b1;
        tick();
        checkOutput("ckpt_restore", 1'b1, 64'h2000, 3'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b11, '0);
        tick();
        ckpt_restore_i = 1'b1;
        tick();
        checkOutput("ckpt_after_flush", 1'b1, 64'h2000, 3'd2, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
